// File: rtl/bcd_seg_decoder.sv
// Registered 8-bit binary to three-digit BCD converter with active-low
// seven-segment encoding. Fixed one-cycle latency, full throughput.

module bcd_seg_encoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // Bit order g,f,e,d,c,b,a; 0 lights a segment. A-F kept for reuse.
    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module bcd_seg_decoder (
    input  logic       CLOCK_24,
    input  logic       RESET_N,
    input  logic [7:0] value,
    input  logic       blank,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_hundreds,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones
);
    logic [11:0] bcd;
    logic [6:0]  enc_hundreds;
    logic [6:0]  enc_tens;
    logic [6:0]  enc_ones;

    // Double-dabble, unrolled: add 3 to any nibble >= 5, then shift in the next bit.
    always_comb begin
        bcd = 12'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], value[i]};
        end
    end

    bcd_seg_encoder u_enc_hundreds (.digit(bcd[11:8]), .seg(enc_hundreds));
    bcd_seg_encoder u_enc_tens     (.digit(bcd[7:4]),  .seg(enc_tens));
    bcd_seg_encoder u_enc_ones     (.digit(bcd[3:0]),  .seg(enc_ones));

    always_ff @(posedge CLOCK_24) begin
        if (!RESET_N) begin
            hundreds     <= 4'd0;
            tens         <= 4'd0;
            ones         <= 4'd0;
            seg_hundreds <= 7'h7F;
            seg_tens     <= 7'h7F;
            seg_ones     <= 7'h7F;
        end else begin
            hundreds     <= bcd[11:8];
            tens         <= bcd[7:4];
            ones         <= bcd[3:0];
            seg_hundreds <= blank ? 7'h7F : enc_hundreds;
            seg_tens     <= blank ? 7'h7F : enc_tens;
            seg_ones     <= blank ? 7'h7F : enc_ones;
        end
    end
endmodule

// File: tb/tb_bcd_seg_decoder.sv
// Scoreboard bench for bcd_seg_decoder: stimulus queues expected outputs,
// a monitor pops and compares one entry per clock after each edge.

module tb_bcd_seg_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'd0;
    logic       blank = 1'b0;
    logic [3:0] hundreds, tens, ones;
    logic [6:0] seg_hundreds, seg_tens, seg_ones;
    logic [3:0] chk_digit = 4'd0;
    logic [6:0] chk_seg;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] h, t, o;
        logic [6:0] sh, st, so;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #21 clk = ~clk;

    bcd_seg_decoder dut (
        .CLOCK_24(clk), .RESET_N(rst_n), .value(value), .blank(blank),
        .hundreds(hundreds), .tens(tens), .ones(ones),
        .seg_hundreds(seg_hundreds), .seg_tens(seg_tens), .seg_ones(seg_ones)
    );

    bcd_seg_encoder u_enc_chk (.digit(chk_digit), .seg(chk_seg));

    task automatic drive(input logic [7:0] v, input logic b, input logic r,
                         input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic [6:0] sh, input logic [6:0] st, input logic [6:0] so,
                         input string nm);
        exp_t e;
        @(negedge clk);
        value = v;
        blank = b;
        rst_n = r;
        e.h = h; e.t = t; e.o = o; e.sh = sh; e.st = st; e.so = so;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if ({hundreds, tens, ones, seg_hundreds, seg_tens, seg_ones} !== e) begin
                    errors++;
                    $display("FAIL %s: got %0d/%0d/%0d seg %h/%h/%h, expected %0d/%0d/%0d seg %h/%h/%h",
                             nm, hundreds, tens, ones, seg_hundreds, seg_tens, seg_ones,
                             e.h, e.t, e.o, e.sh, e.st, e.so);
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0] h, t, o;
        // Reset held two cycles with a nonzero input, then released
        drive(8'd123, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 7'h7F, 7'h7F, 7'h7F, "reset_0");
        drive(8'd123, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 7'h7F, 7'h7F, 7'h7F, "reset_1");
        drive(8'd123, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 7'h79, 7'h24, 7'h30, "release_123");

        // Boundaries
        drive(8'd0,   1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 7'h40, 7'h40, 7'h40, "val_0");
        drive(8'd59,  1'b0, 1'b1, 4'd0, 4'd5, 4'd9, 7'h40, 7'h12, 7'h10, "val_59");
        drive(8'd60,  1'b0, 1'b1, 4'd0, 4'd6, 4'd0, 7'h40, 7'h02, 7'h40, "val_60");
        drive(8'd99,  1'b0, 1'b1, 4'd0, 4'd9, 4'd9, 7'h40, 7'h10, 7'h10, "val_99");
        drive(8'd100, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 7'h79, 7'h40, 7'h40, "val_100");
        drive(8'd255, 1'b0, 1'b1, 4'd2, 4'd5, 4'd5, 7'h24, 7'h12, 7'h12, "val_255");
        drive(8'd5,   1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 7'h40, 7'h40, 7'h12, "val_5");

        // Blank toggling on a steady value
        drive(8'd24, 1'b1, 1'b1, 4'd0, 4'd2, 4'd4, 7'h7F, 7'h7F, 7'h7F, "blank_1a");
        drive(8'd24, 1'b0, 1'b1, 4'd0, 4'd2, 4'd4, 7'h40, 7'h24, 7'h19, "blank_0");
        drive(8'd24, 1'b1, 1'b1, 4'd0, 4'd2, 4'd4, 7'h7F, 7'h7F, 7'h7F, "blank_1b");
        // Blank together with a new value
        drive(8'd187, 1'b1, 1'b1, 4'd1, 4'd8, 4'd7, 7'h7F, 7'h7F, 7'h7F, "blank_new_187");

        // Reset in the middle of a stream
        drive(8'd10, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 7'h40, 7'h79, 7'h40, "ms_10");
        drive(8'd20, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 7'h7F, 7'h7F, 7'h7F, "ms_reset");
        drive(8'd30, 1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 7'h40, 7'h30, 7'h40, "ms_30");

        // Sweep of all inputs, one per cycle
        for (int i = 0; i < 256; i++) begin
            h = 4'(i / 100);
            t = 4'((i % 100) / 10);
            o = 4'(i % 10);
            drive(8'(i), 1'b0, 1'b1, h, t, o, SEG[h], SEG[t], SEG[o], $sformatf("sweep_%0d", i));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        // Encoder glyphs, including A-F unreachable through the digit path
        for (int d = 0; d < 16; d++) begin
            chk_digit = 4'(d);
            #1;
            checks++;
            if (chk_seg !== SEG[d]) begin
                errors++;
                $display("FAIL glyph_%0d: got %h, expected %h", d, chk_seg, SEG[d]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
